handshake_stream_src: RTL and testbench

//   Valid/ready stream transmitter: the producer that drives a downstream

---
 rtl/handshake_stream_src.sv | 153 +++++++++++++++
 tb/tb_handshake_stream_src.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_stream_src.sv
// handshake_stream_src
// Valid/ready burst source. A start command launches a burst of len_i beats
// carrying base_i, base_i+1, ... (wrapping modulo 2^DW). Each beat waits for
// the post-stage to accept it. An optional number of idle cycles can be
// inserted after every accepted beat except the last one.
//
// Handshake contract: a beat transfers on a rising edge where valid_post_o
// and ready_post_i are both 1. Once valid_post_o is raised, it stays high and
// data_post_o stays stable until that transfer happens. ready_post_i never
// reaches an output combinationally.
module handshake_stream_src #(
    parameter int DW    = 8,
    parameter int LEN_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [DW-1:0]    base_i,
    input  logic [GAP_W-1:0] gap_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             valid_post_o,
    output logic [DW-1:0]    data_post_o,
    input  logic             ready_post_i,
    output logic [15:0]      stall_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_ZERO = '0;
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [GAP_W-1:0] GAP_ZERO = '0;
    localparam logic [DW-1:0]    DATA_ONE = DW'(1);
    localparam logic [15:0]      STALL_MAX = 16'hFFFF;

    state_t           state;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] beat_cnt;
    logic [GAP_W-1:0] gap_r;
    logic [GAP_W-1:0] gap_cnt;

    logic xfer;
    logic stall;
    logic last_beat;
    logic stall_sat;

    // Decode the handshake events of the current cycle from registered state.
    always_comb begin
        xfer      = 1'b0;
        stall     = 1'b0;
        last_beat = 1'b0;
        stall_sat = 1'b0;
        if (state == SEND) begin
            xfer  = valid_post_o & ready_post_i;
            stall = valid_post_o & ~ready_post_i;
        end
        last_beat = (beat_cnt == (len_r - LEN_ONE));
        stall_sat = (stall_cnt_o == STALL_MAX);
    end

    // Burst controller: state, handshake outputs, counters, all registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            valid_post_o <= 1'b0;
            data_post_o  <= '0;
            stall_cnt_o  <= '0;
            beat_cnt     <= '0;
            len_r        <= '0;
            gap_r        <= '0;
            gap_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        len_r       <= len_i;
                        gap_r       <= gap_i;
                        beat_cnt    <= '0;
                        stall_cnt_o <= '0;
                        busy_o      <= 1'b1;
                        data_post_o <= base_i;
                        if (len_i != LEN_ZERO) begin
                            // First beat is presented on the cycle after start.
                            state        <= SEND;
                            valid_post_o <= 1'b1;
                        end else begin
                            // Empty burst: straight to the completion pulse.
                            state  <= DONE;
                            done_o <= 1'b1;
                        end
                    end
                end

                SEND: begin
                    if (xfer) begin
                        beat_cnt    <= beat_cnt + LEN_ONE;
                        data_post_o <= data_post_o + DATA_ONE;
                        if (last_beat) begin
                            state        <= DONE;
                            valid_post_o <= 1'b0;
                            done_o       <= 1'b1;
                        end else if (gap_r == GAP_ZERO) begin
                            // Back-to-back: next beat valid immediately.
                            valid_post_o <= 1'b1;
                        end else begin
                            // gap_cnt counts the remaining idle cycles after this one.
                            state        <= GAP;
                            valid_post_o <= 1'b0;
                            gap_cnt      <= gap_r - GAP_ONE;
                        end
                    end else if (stall && !stall_sat) begin
                        stall_cnt_o <= stall_cnt_o + 16'd1;
                    end
                end

                GAP: begin
                    if (gap_cnt == GAP_ZERO) begin
                        state        <= SEND;
                        valid_post_o <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_ONE;
                    end
                end

                DONE: begin
                    // One-cycle completion pulse; stall_cnt_o keeps its value.
                    state  <= IDLE;
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                end

                default: begin
                    state        <= IDLE;
                    busy_o       <= 1'b0;
                    done_o       <= 1'b0;
                    valid_post_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_handshake_stream_src.sv
// Bench for handshake_stream_src: directed bursts with hand-computed beat
// timing plus a long random-ready run, all checked every cycle against a
// transaction-level model (expected beat queue and handshake rules).
module tb_handshake_stream_src;

    logic       clk;
    logic       rst_n;
    logic       start_i;
    logic [7:0] len_i;
    logic [7:0] base_i;
    logic [3:0] gap_i;
    logic       busy_o;
    logic       done_o;
    logic       valid_post_o;
    logic [7:0] data_post_o;
    logic       ready_post_i;
    logic [15:0] stall_cnt_o;

    int vecs = 0;
    int miss = 0;

    handshake_stream_src #(.DW(8), .LEN_W(8), .GAP_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .len_i        (len_i),
        .base_i       (base_i),
        .gap_i        (gap_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .valid_post_o (valid_post_o),
        .data_post_o  (data_post_o),
        .ready_post_i (ready_post_i),
        .stall_cnt_o  (stall_cnt_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic check(input string nm, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- model / scoreboard ----------------
    // exp_q holds the beats still owed in the current burst.
    logic [7:0] exp_q[$];
    bit  m_busy = 0;
    bit  m_done = 0;
    int  m_idle = 0;
    int  m_gap  = 0;
    int  m_stall = 0;
    int  cyc = 0;
    bit  exp_valid;
    bit  was_busy;
    // event log used by the directed literal checks
    logic [7:0] xd_q[$];
    int  xc_q[$];
    int  done_c = -1;
    int  acc_c  = -1;

    // Compare process: mid-cycle, outputs and inputs are stable.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_busy",  int'(busy_o), 0);
            check("rst_done",  int'(done_o), 0);
            check("rst_valid", int'(valid_post_o), 0);
            check("rst_data",  int'(data_post_o), 0);
            check("rst_stall", int'(stall_cnt_o), 0);
            exp_q.delete();
            m_busy = 0; m_done = 0; m_idle = 0; m_stall = 0;
        end else begin
            cyc++;
            exp_valid = m_busy && !m_done && (exp_q.size() > 0) && (m_idle == 0);
            check("busy",  int'(busy_o), int'(m_busy));
            check("done",  int'(done_o), int'(m_done));
            check("valid", int'(valid_post_o), int'(exp_valid));
            check("stall_cnt", int'(stall_cnt_o), m_stall);
            if (exp_valid) check("data", int'(data_post_o), int'(exp_q[0]));
            if (m_done) done_c = cyc;

            was_busy = m_busy;
            if (m_done) begin
                m_busy = 0;
                m_done = 0;
            end else if (exp_valid && ready_post_i) begin
                xd_q.push_back(exp_q[0]);
                xc_q.push_back(cyc);
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) m_done = 1;
                else m_idle = m_gap;
            end else if (exp_valid) begin
                if (m_stall < 65535) m_stall++;
            end else if (m_busy && m_idle > 0) begin
                m_idle--;
            end

            if (!was_busy && start_i) begin
                acc_c   = cyc;
                m_busy  = 1;
                m_stall = 0;
                m_idle  = 0;
                m_gap   = int'(gap_i);
                exp_q.delete();
                for (int i = 0; i < int'(len_i); i++) exp_q.push_back(base_i + 8'(i));
                if (len_i == 8'd0) m_done = 1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_logs();
        xd_q.delete();
        xc_q.delete();
        done_c = -1;
        acc_c  = -1;
    endtask

    // Called at posedge+1; returns at posedge+1 once busy_o has dropped.
    task automatic wait_idle(input bit rnd);
        int k;
        k = 0;
        while (busy_o && k < 3000) begin
            if (rnd) ready_post_i = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            k++;
        end
        vecs++;
        if (busy_o) begin
            miss++;
            $display("FAIL idle_timeout: busy_o still %0d after %0d cycles", busy_o, k);
        end
    endtask

    task automatic run_burst(input int len, input int base, input int gap, input bit rnd);
        start_i = 1'b1;
        len_i   = 8'(len);
        base_i  = 8'(base);
        gap_i   = 4'(gap);
        ready_post_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        wait_idle(rnd);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    int t3_d[3] = '{254, 255, 0};
    int t3_c[3] = '{1, 4, 7};

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; start_i = 1'b0; len_i = '0; base_i = '0; gap_i = '0;
        ready_post_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle_cycles(2);

        // 1: basic burst len=4 base=10 gap=0, ready=1
        clear_logs();
        run_burst(4, 'h10, 0, 0);
        check("t1_nbeats", xd_q.size(), 4);
        for (int i = 0; i < 4; i++) if (i < xd_q.size()) begin
            check("t1_data", int'(xd_q[i]), 'h10 + i);
            check("t1_cyc", xc_q[i] - acc_c, 1 + i);
        end
        check("t1_done_cyc", done_c - acc_c, 5);
        check("t1_stall", int'(stall_cnt_o), 0);
        idle_cycles(1);

        // 2: backpressure, ready low 3 cycles on beat 2 (A1)
        clear_logs();
        start_i = 1'b1; len_i = 8'd3; base_i = 8'hA0; gap_i = 4'd0; ready_post_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        @(posedge clk); #1 ready_post_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 ready_post_i = 1'b1;
        wait_idle(0);
        check("t2_nbeats", xd_q.size(), 3);
        for (int i = 0; i < 3; i++) if (i < xd_q.size())
            check("t2_data", int'(xd_q[i]), 'hA0 + i);
        if (xc_q.size() == 3) begin
            check("t2_cyc1", xc_q[1] - acc_c, 5);
            check("t2_cyc2", xc_q[2] - acc_c, 6);
        end
        check("t2_done_cyc", done_c - acc_c, 7);
        check("t2_stall", int'(stall_cnt_o), 3);
        idle_cycles(2);
        check("t2_stall_hold", int'(stall_cnt_o), 3);

        // 3: gap=2 with data wrap FE,FF,00
        clear_logs();
        run_burst(3, 'hFE, 2, 0);
        check("t3_nbeats", xd_q.size(), 3);
        for (int i = 0; i < 3; i++) if (i < xd_q.size()) begin
            check("t3_data", int'(xd_q[i]), t3_d[i]);
            check("t3_cyc", xc_q[i] - acc_c, t3_c[i]);
        end
        check("t3_done_cyc", done_c - acc_c, 8);

        // 4a: empty burst
        clear_logs();
        run_burst(0, 'h77, 0, 0);
        check("t4_empty_nbeats", xd_q.size(), 0);
        check("t4_empty_done", done_c - acc_c, 1);

        // 4b: start pulsed mid-burst is ignored
        clear_logs();
        start_i = 1'b1; len_i = 8'd5; base_i = 8'h30; gap_i = 4'd0; ready_post_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        @(posedge clk); #1 start_i = 1'b1; len_i = 8'd2; base_i = 8'h99;
        @(posedge clk); #1 start_i = 1'b0;
        wait_idle(0);
        check("t4_nbeats", xd_q.size(), 5);
        for (int i = 0; i < 5; i++) if (i < xd_q.size())
            check("t4_data", int'(xd_q[i]), 'h30 + i);
        check("t4_done_cyc", done_c - acc_c, 6);
        idle_cycles(2);

        // 5: async reset during beat 2 of len=6
        clear_logs();
        start_i = 1'b1; len_i = 8'd6; base_i = 8'h40; gap_i = 4'd0; ready_post_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check("t5_async_valid", int'(valid_post_o), 0);
        check("t5_async_busy",  int'(busy_o), 0);
        check("t5_async_done",  int'(done_o), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle_cycles(1);
        clear_logs();
        run_burst(1, 'h55, 0, 0);
        check("t5_nbeats", xd_q.size(), 1);
        if (xd_q.size() == 1) begin
            check("t5_data", int'(xd_q[0]), 'h55);
            check("t5_cyc", xc_q[0] - acc_c, 1);
        end
        check("t5_done_cyc", done_c - acc_c, 2);

        // 6: maximum length burst, then random ready bursts
        run_burst(255, $urandom_range(0, 255), 0, 1);
        for (int b = 0; b < 1000; b++) begin
            run_burst($urandom_range(0, 10), $urandom_range(0, 255), $urandom_range(0, 3), 1);
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
        end
        idle_cycles(3);
        check("t6_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
